// File: rtl/rmii_rx_frame_if.sv
// Port bundle for the RMII receive framing stage: dibit stream in, framed bytes and statistics out.
interface rmii_rx_frame_if;
   logic        i_rmii_rxvld;
   logic [1:0]  i_rmii_rxdata;
   logic        o_rx_vld;
   logic [7:0]  o_rx_data;
   logic        o_rx_sof;
   logic        o_rx_eof;
   logic        o_rx_err;
   logic        o_rx_crcok;
   logic [15:0] o_frm_cnt;
   logic [15:0] o_err_cnt;

   modport slave (
      input  i_rmii_rxvld, i_rmii_rxdata,
      output o_rx_vld, o_rx_data, o_rx_sof, o_rx_eof, o_rx_err, o_rx_crcok,
      output o_frm_cnt, o_err_cnt
   );

   modport master (
      output i_rmii_rxvld, i_rmii_rxdata,
      input  o_rx_vld, o_rx_data, o_rx_sof, o_rx_eof, o_rx_err, o_rx_crcok,
      input  o_frm_cnt, o_err_cnt
   );
endinterface

// File: rtl/rmii_rx_frame.sv
// RMII receive framing: preamble/SFD hunt, LSB-first byte assembly, CRC-32 check,
// one-byte hold so the last byte can carry eof/err/crcok, and frame/error statistics.
module rmii_rx_frame #(
   parameter int P_GAP_CYC = 4,
   parameter int P_MIN_PRE = 4,
   parameter int P_MIN_LEN = 64,
   parameter int P_MAX_LEN = 1518
) (
   input  logic           i_clk,
   input  logic           i_rst,
   rmii_rx_frame_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_DROP, ST_DATA} state_t;

   localparam logic [3:0]  GAP_MAX     = 4'(P_GAP_CYC);
   localparam logic [3:0]  GAP_LAST    = 4'(P_GAP_CYC - 1);
   localparam logic [4:0]  PRE_MAX     = 5'd31;
   localparam logic [10:0] LEN_MAX     = 11'd2047;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   state_t      state_q,     state_d;
   logic [3:0]  gap_q,       gap_d;
   logic [4:0]  pre_q,       pre_d;
   logic [1:0]  phase_q,     phase_d;
   logic [5:0]  shift_q,     shift_d;
   logic [10:0] len_q,       len_d;
   logic [31:0] crc_q,       crc_d;
   logic        crc_pend_q,  crc_pend_d;
   logic [7:0]  crc_byte_q,  crc_byte_d;
   logic [7:0]  hold_q,      hold_d;
   logic        hold_full_q, hold_full_d;
   logic        sof_pend_q,  sof_pend_d;

   logic        vld_q,   vld_d;
   logic [7:0]  data_q,  data_d;
   logic        sof_q,   sof_d;
   logic        eof_q,   eof_d;
   logic        err_q,   err_d;
   logic        crcok_q, crcok_d;
   logic [15:0] frm_q,   frm_d;
   logic [15:0] errc_q,  errc_d;

   logic        gap_event;
   logic [7:0]  new_byte;
   logic        crc_ok;
   logic        frame_bad;

   // The gap event fires only on the cycle the idle run first reaches P_GAP_CYC.
   assign gap_event = !bus.i_rmii_rxvld && (gap_q == GAP_LAST);
   assign new_byte  = {bus.i_rmii_rxdata, shift_q};
   assign crc_ok    = (crc_q == CRC_RESIDUE);
   assign frame_bad = !crc_ok || (int'(len_q) < P_MIN_LEN) || (int'(len_q) > P_MAX_LEN) ||
                      (phase_q != 2'd0);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      pre_d       = pre_q;
      phase_d     = phase_q;
      shift_d     = shift_q;
      len_d       = len_q;
      crc_d       = crc_pend_q ? crc_next(crc_q, crc_byte_q) : crc_q;
      crc_pend_d  = 1'b0;
      crc_byte_d  = crc_byte_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sof_pend_d  = sof_pend_q;
      vld_d       = 1'b0;
      data_d      = data_q;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      err_d       = 1'b0;
      crcok_d     = 1'b0;
      frm_d       = frm_q;
      errc_d      = errc_q;

      if (bus.i_rmii_rxvld)      gap_d = 4'd0;
      else if (gap_q != GAP_MAX) gap_d = gap_q + 4'd1;
      else                       gap_d = gap_q;

      case (state_q)
         ST_IDLE: begin
            if (gap_event) begin
               pre_d = 5'd0;
            end else if (bus.i_rmii_rxvld) begin
               if (bus.i_rmii_rxdata == 2'b01) begin
                  pre_d = (pre_q == PRE_MAX) ? PRE_MAX : pre_q + 5'd1;
               end else if (bus.i_rmii_rxdata == 2'b11 && int'(pre_q) >= P_MIN_PRE) begin
                  state_d     = ST_DATA;
                  pre_d       = 5'd0;
                  phase_d     = 2'd0;
                  len_d       = 11'd0;
                  crc_d       = CRC_INIT;
                  hold_full_d = 1'b0;
                  sof_pend_d  = 1'b1;
               end else begin
                  state_d = ST_DROP;
                  pre_d   = 5'd0;
               end
            end
         end

         ST_DROP: begin
            if (gap_event) state_d = ST_IDLE;
         end

         ST_DATA: begin
            if (bus.i_rmii_rxvld) begin
               shift_d = new_byte[7:2];
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd3) begin
                  crc_pend_d  = 1'b1;
                  crc_byte_d  = new_byte;
                  len_d       = (len_q == LEN_MAX) ? LEN_MAX : len_q + 11'd1;
                  hold_d      = new_byte;
                  hold_full_d = 1'b1;
                  // The held byte is released only once its successor exists, so eof can ride on the last one.
                  if (hold_full_q) begin
                     vld_d      = 1'b1;
                     data_d     = hold_q;
                     sof_d      = sof_pend_q;
                     sof_pend_d = 1'b0;
                  end
               end
            end else if (gap_event) begin
               state_d     = ST_IDLE;
               hold_full_d = 1'b0;
               if (hold_full_q) begin
                  vld_d   = 1'b1;
                  data_d  = hold_q;
                  sof_d   = sof_pend_q;
                  eof_d   = 1'b1;
                  err_d   = frame_bad;
                  crcok_d = crc_ok;
                  frm_d   = frm_q + 16'd1;
                  if (frame_bad) errc_d = errc_q + 16'd1;
               end else begin
                  // SFD followed by no complete byte: counted as a silently dropped frame.
                  errc_d = errc_q + 16'd1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
      if (i_rst) begin
         state_q     <= ST_IDLE;
         gap_q       <= 4'd0;
         pre_q       <= 5'd0;
         phase_q     <= 2'd0;
         shift_q     <= 6'd0;
         len_q       <= 11'd0;
         crc_q       <= CRC_INIT;
         crc_pend_q  <= 1'b0;
         crc_byte_q  <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         sof_pend_q  <= 1'b0;
         vld_q       <= 1'b0;
         data_q      <= 8'd0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         err_q       <= 1'b0;
         crcok_q     <= 1'b0;
         frm_q       <= 16'd0;
         errc_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         pre_q       <= pre_d;
         phase_q     <= phase_d;
         shift_q     <= shift_d;
         len_q       <= len_d;
         crc_q       <= crc_d;
         crc_pend_q  <= crc_pend_d;
         crc_byte_q  <= crc_byte_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sof_pend_q  <= sof_pend_d;
         vld_q       <= vld_d;
         data_q      <= data_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         err_q       <= err_d;
         crcok_q     <= crcok_d;
         frm_q       <= frm_d;
         errc_q      <= errc_d;
      end
   end

   assign bus.o_rx_vld   = vld_q;
   assign bus.o_rx_data  = data_q;
   assign bus.o_rx_sof   = sof_q;
   assign bus.o_rx_eof   = eof_q;
   assign bus.o_rx_err   = err_q;
   assign bus.o_rx_crcok = crcok_q;
   assign bus.o_frm_cnt  = frm_q;
   assign bus.o_err_cnt  = errc_q;

endmodule

// File: tb/tb_rmii_rx_frame.sv
// Randomized bench for rmii_rx_frame: a frame-level reference model splits the dibit stream at
// gap events, parses each burst and predicts every output beat, its cycle and the counters.
module tb_rmii_rx_frame;

   localparam int G       = 4;
   localparam int MIN_PRE = 4;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rmii_rx_frame_if bus ();

   rmii_rx_frame #(
      .P_GAP_CYC(G),
      .P_MIN_PRE(MIN_PRE),
      .P_MIN_LEN(MIN_LEN),
      .P_MAX_LEN(MAX_LEN)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit          s_vld[$];
   bit [1:0]    s_dat[$];
   bit          s_rst[$];
   logic [7:0]  fb[$];
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];
   int          rst_chk[$];
   bit [1:0]    seg_d[$];
   int          seg_i[$];
   int          m_zero = 0;
   logic [15:0] m_frm  = 16'd0;
   logic [15:0] m_err  = 16'd0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [63:0] rec(input int stamp, input logic [15:0] f, input logic [15:0] e,
                                       input logic [7:0] d, input logic sof, input logic eof,
                                       input logic err, input logic ok);
      return {20'(stamp), f, e, d, sof, eof, err, ok};
   endfunction

   task automatic push(input bit v, input bit [1:0] d, input bit r);
      s_vld.push_back(v);
      s_dat.push_back(d);
      s_rst.push_back(r);
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 2'b00, 1'b0);
   endtask

   task automatic build_good(input int npay);
      logic [31:0] crc;
      logic [7:0]  b;
      fb.delete();
      crc = 32'hFFFF_FFFF;
      for (int i = 0; i < npay; i++) begin
         b = 8'($urandom);
         fb.push_back(b);
         crc = crc_upd(crc, b);
      end
      crc = ~crc;
      for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
   endtask

   task automatic build_raw(input int n);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
   endtask

   // npre 01-dibits + SFD + fb bytes LSB dibit first, with optional stalls, split, extra dibits, reset.
   task automatic push_frame(input int npre, input int st_every, input int st_len, input int split_at,
                             input int extra, input int rst_at, input int tail);
      bit [1:0]   dq[$];
      logic [7:0] b;
      for (int i = 0; i < npre; i++) dq.push_back(2'b01);
      dq.push_back(2'b11);
      for (int i = 0; i < fb.size(); i++) begin
         b = fb[i];
         for (int k = 0; k < 4; k++) dq.push_back(b[2*k +: 2]);
      end
      for (int i = 0; i < extra; i++) dq.push_back(2'($urandom));
      for (int i = 0; i < dq.size(); i++) begin
         if (i == rst_at) push(1'b0, 2'b00, 1'b1);
         push(1'b1, dq[i], 1'b0);
         if (st_every > 0 && (i + 1) % st_every == 0) push_idle(st_len);
         if (i == split_at) push_idle(G);
      end
      push_idle(tail);
   endtask

   // One burst between gap events (or cut short by reset): preamble rule, then bytes, FCS residue, length.
   task automatic model_frame(input int g, input bit aborted);
      int k, cnt, fs, n, ln;
      logic [31:0] crc;
      logic [7:0]  b;
      bit e, ok;
      k = 0;
      cnt = 0;
      while (k < seg_d.size() && seg_d[k] == 2'b01) begin
         k++;
         cnt++;
      end
      if (k >= seg_d.size()) return;
      if (!(seg_d[k] == 2'b11 && cnt >= MIN_PRE)) return;
      k++;
      fs = seg_d.size() - k;
      n  = fs / 4;
      if (n == 0) begin
         if (!aborted) m_err++;
         return;
      end
      crc = 32'hFFFF_FFFF;
      for (int m = 0; m < n; m++) begin
         b   = {seg_d[k+4*m+3], seg_d[k+4*m+2], seg_d[k+4*m+1], seg_d[k+4*m]};
         crc = crc_upd(crc, b);
         if (m < n - 1) begin
            exp_q.push_back(rec(seg_i[k+4*(m+1)+3] + 1, m_frm, m_err, b, m == 0, 1'b0, 1'b0, 1'b0));
         end else if (!aborted) begin
            ok = (crc == 32'hDEBB_20E3);
            ln = (n > 2047) ? 2047 : n;
            e  = !ok || ln < MIN_LEN || ln > MAX_LEN || (fs % 4) != 0;
            m_frm++;
            if (e) m_err++;
            exp_q.push_back(rec(g + 1, m_frm, m_err, b, m == 0, 1'b1, e, ok));
         end
      end
   endtask

   task automatic model_run();
      int idx;
      for (int j = 0; j < s_vld.size(); j++) begin
         idx = cyc + j;
         if (s_rst[j]) begin
            model_frame(0, 1'b1);
            seg_d.delete();
            seg_i.delete();
            m_zero = 0;
            m_frm  = 16'd0;
            m_err  = 16'd0;
            rst_chk.push_back(idx + 1);
         end else if (s_vld[j]) begin
            m_zero = 0;
            seg_d.push_back(s_dat[j]);
            seg_i.push_back(idx);
         end else if (m_zero < G) begin
            m_zero++;
            if (m_zero == G) begin
               model_frame(idx, 1'b0);
               seg_d.delete();
               seg_i.delete();
            end
         end
      end
   endtask

   task automatic monitor();
      if (bus.o_rx_vld === 1'b1)
         got_q.push_back(rec(cyc, bus.o_frm_cnt, bus.o_err_cnt, bus.o_rx_data, bus.o_rx_sof,
                             bus.o_rx_eof, bus.o_rx_err, bus.o_rx_crcok));
      if (rst_chk.size() > 0 && rst_chk[0] == cyc) begin
         void'(rst_chk.pop_front());
         check("reset_clear", {bus.o_rx_vld, bus.o_rx_sof, bus.o_rx_eof, bus.o_rx_err, bus.o_rx_crcok,
                               bus.o_rx_data, bus.o_frm_cnt, bus.o_err_cnt}, 64'd0);
      end
   endtask

   task automatic run_test(input string name);
      int n;
      push_idle(2);
      model_run();
      for (int j = 0; j < s_vld.size(); j++) begin
         @(negedge clk);
         monitor();
         bus.i_rmii_rxvld  = s_vld[j];
         bus.i_rmii_rxdata = s_dat[j];
         rst               = s_rst[j];
         cyc++;
      end
      check({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
      check({name, "_counters"}, {32'd0, bus.o_frm_cnt, bus.o_err_cnt}, {32'd0, m_frm, m_err});
      got_q.delete();
      exp_q.delete();
      s_vld.delete();
      s_dat.delete();
      s_rst.delete();
   endtask

   initial begin
      int npre, st_every, st_len, extra;
      bus.i_rmii_rxvld  = 1'b0;
      bus.i_rmii_rxdata = 2'b00;

      for (int i = 0; i < 3; i++) push(1'b0, 2'b00, 1'b1);
      push_idle(G + 2);
      run_test("reset");

      build_good(60);
      push_frame(31, 0, 0, -1, 0, -1, G + 2);
      run_test("good");

      fb[63] = fb[63] ^ 8'h01;
      push_frame(31, 0, 0, -1, 0, -1, G + 2);
      run_test("bad_fcs");

      build_good(16);
      push_frame(31, 0, 0, -1, 0, -1, G + 2);
      run_test("runt");

      build_good(1596);
      push_frame(31, 0, 0, -1, 0, -1, G + 2);
      run_test("oversize");

      build_good(60);
      push_frame(31, 0, 0, -1, 1, -1, G + 2);
      run_test("dribble");

      build_good(60);
      push_frame(31, 5, 3, -1, 0, -1, G + 2);
      run_test("stall");

      push_frame(31, 0, 0, 160, 0, -1, G + 2);
      run_test("split");

      push(1'b1, 2'b01, 1'b0);
      push(1'b1, 2'b01, 1'b0);
      push(1'b1, 2'b11, 1'b0);
      for (int i = 0; i < 40; i++) push(1'b1, 2'($urandom), 1'b0);
      push_idle(G + 2);
      run_test("pre_err");

      build_good(60);
      push_frame(31, 0, 0, -1, 0, 150, G + 2);
      build_good(60);
      push_frame(31, 0, 0, -1, 0, -1, G + 2);
      run_test("rst_mid");

      // Back-to-back frames with exactly G idle cycles: random length, preamble, stalls, corruption, dribble.
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 9) == 0) build_raw($urandom_range(0, 3));
         else                           build_good($urandom_range(0, 70));
         if (fb.size() > 0 && $urandom_range(0, 4) == 0)
            fb[fb.size()-1] = fb[fb.size()-1] ^ (8'd1 << $urandom_range(0, 7));
         npre     = $urandom_range(2, 33);
         st_every = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 9) : 0;
         st_len   = $urandom_range(1, G - 1);
         extra    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         push_frame(npre, st_every, st_len, -1, extra, -1, G);
      end
      run_test("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rmii_rx_frame.md
# rmii_rx_frame

Receive-side framing stage that sits directly downstream of the RMII receive front end in the Ethernet path. It consumes the dibit stream (`i_rmii_rxvld`/`i_rmii_rxdata`) already moved into the `i_clk` domain. It hunts for preamble/SFD, assembles bytes LSB-dibit first and checks the Ethernet FCS (CRC-32). It then presents whole frames as a byte stream with start/end/error markers and keeps frame/error statistics for the MAC layer.

## Interface
- `P_GAP_CYC`, 4: consecutive `i_rmii_rxvld`=0 cycles that terminate a frame (2..15).
- `P_MIN_PRE`, 4: minimum 01 preamble dibits required before the SFD 11 dibit.
- `P_MIN_LEN`, 64: minimum legal frame bytes after SFD, including FCS.
- `P_MAX_LEN`, 1518: maximum legal frame bytes after SFD, including FCS.
- `i_clk` in 1: system clock, same clock as the upstream RMII receive stage output.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_rmii_rxvld` in 1: dibit strobe; one dibit per high cycle.
- `i_rmii_rxdata` in 2: dibit; first dibit of a byte is byte[1:0].
- `o_rx_vld` out 1: one-cycle byte strobe.
- `o_rx_data` out 8: frame byte (DA first, FCS bytes included).
- `o_rx_sof` out 1: qualifies the first byte of a frame.
- `o_rx_eof` out 1: qualifies the last byte of a frame.
- `o_rx_err` out 1: valid with `o_rx_eof`. Set on bad FCS, length out of range, or dangling dibits.
- `o_rx_crcok` out 1: valid with `o_rx_eof`; FCS residue matched.
- `o_frm_cnt` out 16: frames ended with `o_rx_eof`; wraps.
- `o_err_cnt` out 16: frames ended with `o_rx_err`=1, plus silently dropped frames; wraps.

## Operation
- Reset: state IDLE. All outputs 0, counters 0, CRC register `0xFFFFFFFF`. Held-byte register empty, gap counter 0.
- Gap counter: counts consecutive `i_rmii_rxvld`=0 cycles and saturates at `P_GAP_CYC`. It clears on any `i_rmii_rxvld`=1. A "gap event" is the cycle the counter reaches `P_GAP_CYC`. Shorter stalls inside a frame are transparent.
- IDLE: on each valid dibit:
  - 01: preamble count +1, saturating at 31.
  - 11 with count ≥ `P_MIN_PRE`: go to DATA, with dibit phase 0, length 0, CRC `0xFFFFFFFF`.
  - Any other dibit, or 11 with count < `P_MIN_PRE`: go to DROP.
  - A gap event in IDLE clears the preamble count.
- DROP: ignores dibits. On a gap event it goes to IDLE, with no output and no counter change.
- DATA:
  - Dibits shift into the byte register at phase 0..3. Phase 3 completes a byte.
  - Each completed byte updates the CRC: reflected polynomial `0xEDB88320`, LSB first, no final XOR.
  - Each completed byte increments the length (11 bits, saturating at 2047).
  - A completed byte goes into the one-byte hold register. If the hold register was occupied, its previous content is emitted (`o_rx_vld`=1, `o_rx_sof`=1 for the first emission of the frame).
- End of frame (gap event while in DATA):
  - Hold register occupied: emit it with `o_rx_eof`=1.
  - `o_rx_crcok` = (CRC == `0xDEBB20E3`).
  - `o_rx_err` = !crcok | length < `P_MIN_LEN` | length > `P_MAX_LEN` | phase≠0.
  - `o_frm_cnt`+1; `o_err_cnt`+1 if err. Then go to IDLE.
  - Single-byte frame: `o_rx_sof` and `o_rx_eof` are both 1 on the same beat.
  - Zero bytes after SFD: no emission, `o_err_cnt`+1, `o_frm_cnt` unchanged.
- Oversize frames are emitted in full. `o_rx_err` flags the violation; nothing is truncated.
- Reset mid-frame: outputs drop to 0 the cycle after `i_rst` is sampled. The tail of the interrupted frame is rejected via IDLE/DROP because its data dibits are not a preamble.

## Timing
- `o_rx_vld`, `o_rx_sof`, `o_rx_eof`, `o_rx_err`, `o_rx_crcok` are registered single-cycle pulses; `o_rx_data` is registered.
- Byte N is emitted one cycle after the cycle whose dibit completes byte N+1.
- The last byte is emitted one cycle after the gap event, i.e. `P_GAP_CYC`+1 cycles after the final dibit.
- The CRC is updated one cycle after byte completion, so it is always final before the gap event (`P_GAP_CYC` ≥ 2).
- The counters update in the same cycle as `o_rx_eof`.
- Back-to-back frames need only `P_GAP_CYC` idle cycles between them. The SFD of the next frame may follow the gap event immediately.

## Test plan
- Good frame: 7×0x55 + 0xD5 + 60 payload bytes + correct FCS, with `i_rmii_rxvld` continuous. Required: 64 beats, sof on beat 0, eof on beat 63, crcok=1, err=0, frm_cnt=1, err_cnt=0.
- Same frame with the last FCS byte XOR 0x01. Required: eof with crcok=0, err=1, err_cnt=1.
- Runt: 20 bytes with valid FCS. Required: crcok=1, err=1. Then a 1600-byte frame. Required: all 1600 bytes emitted, err=1.
- Dribble: good 64-byte frame plus one extra dibit before the gap. Required: 64 beats, err=1.
- Stalls: good frame with `i_rmii_rxvld` low for 3 cycles every 5 dibits (`P_GAP_CYC`=4). Required: identical output to the first case. A 4-cycle stall mid-frame splits it and produces err=1.
- Preamble error: only 2×01 dibits then 11. Required: no output, counters unchanged. Then `i_rst` pulsed mid-frame during a good frame. Required: outputs 0 next cycle, no emission for the remnant, and the following good frame received correctly.
